// File: rtl/vga_plot_arbiter_if.sv
// Bundle between the drawing engines and the plot arbiter: per-requester
// request/plot lanes in, granted pixel stream and status out.
interface vga_plot_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int X_W     = 8,
   parameter int Y_W     = 7,
   parameter int C_W     = 3
) ();
   logic [NUM_REQ-1:0]     req;
   logic [NUM_REQ-1:0]     gnt;
   logic [NUM_REQ-1:0]     plot_in;
   logic [NUM_REQ*X_W-1:0] x_in;
   logic [NUM_REQ*Y_W-1:0] y_in;
   logic [NUM_REQ*C_W-1:0] colour_in;
   logic [X_W-1:0]         vga_x;
   logic [Y_W-1:0]         vga_y;
   logic [C_W-1:0]         vga_colour;
   logic                   vga_plot;
   logic                   busy;
   logic [15:0]            clip_cnt;

   modport master (
      output req, plot_in, x_in, y_in, colour_in,
      input  gnt, vga_x, vga_y, vga_colour, vga_plot, busy, clip_cnt
   );

   modport slave (
      input  req, plot_in, x_in, y_in, colour_in,
      output gnt, vga_x, vga_y, vga_colour, vga_plot, busy, clip_cnt
   );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Round-robin, burst-locked arbiter sharing one VGA plot port among several
// drawing engines; off-screen plots are suppressed and counted.
module vga_plot_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int X_W     = 8,
   parameter int Y_W     = 7,
   parameter int C_W     = 3,
   parameter int X_MAX   = 159,
   parameter int Y_MAX   = 119
) (
   input logic               clk,
   input logic               rst_n,
   vga_plot_arbiter_if.slave bus
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic {
      S_IDLE,
      S_OWNED
   } state_t;

   state_t             r_state;
   state_t             w_stateNext;
   logic [IDX_W-1:0]   r_last;
   logic [IDX_W-1:0]   w_lastNext;
   logic [NUM_REQ-1:0] r_gnt;
   logic [NUM_REQ-1:0] w_gntNext;

   logic               w_found;
   logic [IDX_W-1:0]   w_pick;

   logic               w_hit;
   logic [IDX_W-1:0]   w_sel;
   logic [X_W-1:0]     w_x;
   logic [Y_W-1:0]     w_y;
   logic [C_W-1:0]     w_colour;
   logic               w_inRange;

   logic [X_W-1:0]     r_vgaX;
   logic [Y_W-1:0]     r_vgaY;
   logic [C_W-1:0]     r_vgaColour;
   logic               r_vgaPlot;
   logic [15:0]        r_clipCnt;

   // Round-robin search starting just past the last owner. The last owner is
   // checked last, so a releasing requester only wins when nobody else asks.
   always_comb begin : search
      int idx;
      idx     = 0;
      w_found = 1'b0;
      w_pick  = r_last;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(r_last) + k) % NUM_REQ;
         if (!w_found && bus.req[idx]) begin
            w_found = 1'b1;
            w_pick  = IDX_W'(idx);
         end
      end
   end

   always_comb begin
      w_stateNext = r_state;
      w_lastNext  = r_last;
      w_gntNext   = r_gnt;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_stateNext       = S_OWNED;
               w_lastNext        = w_pick;
               w_gntNext         = '0;
               w_gntNext[w_pick] = 1'b1;
            end
         end
         S_OWNED: begin
            // r_last always names the current owner while a grant is held.
            if (!bus.req[r_last]) begin
               if (w_found) begin
                  w_lastNext        = w_pick;
                  w_gntNext         = '0;
                  w_gntNext[w_pick] = 1'b1;
               end else begin
                  w_stateNext = S_IDLE;
                  w_gntNext   = '0;
               end
            end
         end
         default: begin
            w_stateNext = S_IDLE;
            w_gntNext   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_last  <= IDX_W'(NUM_REQ - 1);
         r_gnt   <= '0;
      end else begin
         r_state <= w_stateNext;
         r_last  <= w_lastNext;
         r_gnt   <= w_gntNext;
      end
   end

   // Only the registered grant qualifies a plot strobe; others are ignored.
   always_comb begin
      w_hit = 1'b0;
      w_sel = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_gnt[i] && bus.plot_in[i]) begin
            w_hit = 1'b1;
            w_sel = IDX_W'(i);
         end
      end
      w_x       = bus.x_in[int'(w_sel)*X_W +: X_W];
      w_y       = bus.y_in[int'(w_sel)*Y_W +: Y_W];
      w_colour  = bus.colour_in[int'(w_sel)*C_W +: C_W];
      w_inRange = (w_x <= X_W'(X_MAX)) && (w_y <= Y_W'(Y_MAX));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vgaX      <= '0;
         r_vgaY      <= '0;
         r_vgaColour <= '0;
         r_vgaPlot   <= 1'b0;
         r_clipCnt   <= '0;
      end else if (w_hit) begin
         r_vgaX      <= w_x;
         r_vgaY      <= w_y;
         r_vgaColour <= w_colour;
         r_vgaPlot   <= w_inRange;
         if (!w_inRange && (r_clipCnt != 16'hFFFF)) begin
            r_clipCnt <= r_clipCnt + 16'd1;
         end
      end else begin
         r_vgaPlot <= 1'b0;
      end
   end

   assign bus.gnt        = r_gnt;
   assign bus.busy       = |r_gnt;
   assign bus.vga_x      = r_vgaX;
   assign bus.vga_y      = r_vgaY;
   assign bus.vga_colour = r_vgaColour;
   assign bus.vga_plot   = r_vgaPlot;
   assign bus.clip_cnt   = r_clipCnt;
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter with hand-computed expectations
// checked by immediate assertions.
module tb_vga_plot_arbiter;
   logic clk;
   logic rst_n;
   int   nVectors;
   int   nMiscompares;
   int   nPulses;

   vga_plot_arbiter_if #(.NUM_REQ(2), .X_W(8), .Y_W(7), .C_W(3)) bus ();

   vga_plot_arbiter #(
      .NUM_REQ(2), .X_W(8), .Y_W(7), .C_W(3), .X_MAX(159), .Y_MAX(119)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic [1:0] req, input logic [1:0] plot,
                                input logic [7:0] x0, input logic [6:0] y0,
                                input logic [2:0] c0, input logic [7:0] x1,
                                input logic [6:0] y1, input logic [2:0] c1);
      bus.req       = req;
      bus.plot_in   = plot;
      bus.x_in      = {x1, x0};
      bus.y_in      = {y1, y0};
      bus.colour_in = {c1, c0};
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nVectors++;
      assert (observed === expected)
      else begin
         nMiscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic pulseReset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      nVectors     = 0;
      nMiscompares = 0;
      nPulses      = 0;
      rst_n        = 1'b0;
      applyStimulus(2'b00, 2'b00, 8'd0, 7'd0, 3'd0, 8'd0, 7'd0, 3'd0);
      tick();
      tick();
      checkOutput("rst_gnt", 32'(bus.gnt), 32'h0);
      checkOutput("rst_busy", 32'(bus.busy), 32'h0);
      checkOutput("rst_plot", 32'(bus.vga_plot), 32'h0);
      checkOutput("rst_x", 32'(bus.vga_x), 32'h0);
      checkOutput("rst_clip", 32'(bus.clip_cnt), 32'h0);
      rst_n = 1'b1;

      // Single grant and one in-range plot
      applyStimulus(2'b01, 2'b00, 8'd5, 7'd7, 3'd3, 8'd0, 7'd0, 3'd0);
      tick();
      checkOutput("t1_gnt", 32'(bus.gnt), 32'h1);
      checkOutput("t1_busy", 32'(bus.busy), 32'h1);
      applyStimulus(2'b01, 2'b01, 8'd5, 7'd7, 3'd3, 8'd0, 7'd0, 3'd0);
      tick();
      checkOutput("t1_plot", 32'(bus.vga_plot), 32'h1);
      checkOutput("t1_x", 32'(bus.vga_x), 32'd5);
      checkOutput("t1_y", 32'(bus.vga_y), 32'd7);
      checkOutput("t1_c", 32'(bus.vga_colour), 32'd3);
      applyStimulus(2'b01, 2'b00, 8'd0, 7'd0, 3'd0, 8'd0, 7'd0, 3'd0);
      tick();
      checkOutput("t1_plot_off", 32'(bus.vga_plot), 32'h0);
      checkOutput("t1_x_hold", 32'(bus.vga_x), 32'd5);
      applyStimulus(2'b00, 2'b00, 8'd0, 7'd0, 3'd0, 8'd0, 7'd0, 3'd0);
      tick();
      checkOutput("t1_idle_gnt", 32'(bus.gnt), 32'h0);
      checkOutput("t1_idle_busy", 32'(bus.busy), 32'h0);

      // Round-robin handover with burst lock
      pulseReset();
      applyStimulus(2'b11, 2'b00, 8'd0, 7'd0, 3'd0, 8'd0, 7'd0, 3'd0);
      tick();
      checkOutput("t2_first", 32'(bus.gnt), 32'h1);
      tick();
      checkOutput("t2_lock", 32'(bus.gnt), 32'h1);
      applyStimulus(2'b10, 2'b00, 8'd0, 7'd0, 3'd0, 8'd0, 7'd0, 3'd0);
      tick();
      checkOutput("t2_hand1", 32'(bus.gnt), 32'h2);
      checkOutput("t2_nogap", 32'(bus.busy), 32'h1);
      applyStimulus(2'b01, 2'b00, 8'd0, 7'd0, 3'd0, 8'd0, 7'd0, 3'd0);
      tick();
      checkOutput("t2_hand0", 32'(bus.gnt), 32'h1);
      applyStimulus(2'b11, 2'b00, 8'd0, 7'd0, 3'd0, 8'd0, 7'd0, 3'd0);
      tick();
      checkOutput("t2_lock2", 32'(bus.gnt), 32'h1);

      // Plot from the non-owner is dropped
      applyStimulus(2'b11, 2'b10, 8'd0, 7'd0, 3'd0, 8'd9, 7'd4, 3'd6);
      tick();
      checkOutput("t3_plot", 32'(bus.vga_plot), 32'h0);
      checkOutput("t3_clip", 32'(bus.clip_cnt), 32'h0);
      checkOutput("t3_x", 32'(bus.vga_x), 32'h0);

      // Clipping boundaries
      applyStimulus(2'b01, 2'b01, 8'd160, 7'd0, 3'd1, 8'd0, 7'd0, 3'd0);
      tick();
      checkOutput("t4_xclip_plot", 32'(bus.vga_plot), 32'h0);
      checkOutput("t4_xclip_cnt", 32'(bus.clip_cnt), 32'd1);
      checkOutput("t4_xclip_x", 32'(bus.vga_x), 32'd160);
      applyStimulus(2'b01, 2'b01, 8'd0, 7'd120, 3'd2, 8'd0, 7'd0, 3'd0);
      tick();
      checkOutput("t4_yclip_plot", 32'(bus.vga_plot), 32'h0);
      checkOutput("t4_yclip_cnt", 32'(bus.clip_cnt), 32'd2);
      checkOutput("t4_yclip_y", 32'(bus.vga_y), 32'd120);
      applyStimulus(2'b01, 2'b01, 8'd159, 7'd119, 3'd7, 8'd0, 7'd0, 3'd0);
      tick();
      checkOutput("t4_edge_plot", 32'(bus.vga_plot), 32'h1);
      checkOutput("t4_edge_cnt", 32'(bus.clip_cnt), 32'd2);
      applyStimulus(2'b01, 2'b01, 8'd200, 7'd0, 3'd0, 8'd0, 7'd0, 3'd0);
      for (int n = 0; n < 65540; n++) tick();
      checkOutput("t4_sat", 32'(bus.clip_cnt), 32'hFFFF);
      tick();
      checkOutput("t4_sat_hold", 32'(bus.clip_cnt), 32'hFFFF);

      // Full-screen sweep at one pixel per clock
      pulseReset();
      applyStimulus(2'b01, 2'b00, 8'd0, 7'd0, 3'd0, 8'd0, 7'd0, 3'd0);
      tick();
      checkOutput("t5_gnt", 32'(bus.gnt), 32'h1);
      for (int y = 0; y < 120; y++) begin
         for (int x = 0; x < 160; x++) begin
            applyStimulus(2'b01, 2'b01, 8'(x), 7'(y), 3'(x), 8'd0, 7'd0, 3'd0);
            tick();
            if (bus.vga_plot) nPulses++;
         end
      end
      applyStimulus(2'b01, 2'b00, 8'd0, 7'd0, 3'd0, 8'd0, 7'd0, 3'd0);
      tick();
      if (bus.vga_plot) nPulses++;
      checkOutput("t5_pulses", 32'(nPulses), 32'd19200);
      checkOutput("t5_clip", 32'(bus.clip_cnt), 32'h0);
      checkOutput("t5_x", 32'(bus.vga_x), 32'd159);
      checkOutput("t5_y", 32'(bus.vga_y), 32'd119);

      // Asynchronous reset in the middle of a burst
      applyStimulus(2'b01, 2'b01, 8'd10, 7'd10, 3'd5, 8'd0, 7'd0, 3'd0);
      tick();
      checkOutput("t6_pre_plot", 32'(bus.vga_plot), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("t6_gnt", 32'(bus.gnt), 32'h0);
      checkOutput("t6_plot", 32'(bus.vga_plot), 32'h0);
      checkOutput("t6_busy", 32'(bus.busy), 32'h0);
      tick();
      rst_n = 1'b1;
      applyStimulus(2'b10, 2'b00, 8'd0, 7'd0, 3'd0, 8'd0, 7'd0, 3'd0);
      tick();
      checkOutput("t6_regrant", 32'(bus.gnt), 32'h2);

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end
endmodule
